lab2_proc_alu_arb: RTL

Shares one instance of the processor ALU (lab2_proc_ProcDpathAlu) between two requesters, e.g. the X stage and an auxiliary unit (branch-target or address-generation helper). Each requester has its own val/rdy request and response channels. A 2-way round-robin arbiter issues at most one operation per cycle. Results are registered in a one-entry response buffer per port, giving one-cycle latency and full throughput.

---
 rtl/lab2_proc_alu_pkg.sv | 47 ++++
 rtl/lab2_proc_ProcDpathAlu.sv | 46 ++++
 rtl/lab2_proc_alu_rr_arb2.sv | 34 +++
 rtl/lab2_proc_alu_arb.sv | 117 +++++++++++
 4 files changed

// File: rtl/lab2_proc_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lab2_proc_alu_pkg
// Brief    : ALU function codes, request/response message layouts and helpers
// Revision : 1.0
// ============================================================================
package lab2_proc_alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SLL  = 4'd9;
    localparam logic [3:0] ALU_CP0  = 4'd11;
    localparam logic [3:0] ALU_CP1  = 4'd12;

    typedef struct packed {
        logic [3:0]  fn;
        logic [31:0] in0;
        logic [31:0] in1;
    } alu_req_msg_t;

    typedef struct packed {
        logic        err;
        logic        ltu;
        logic        lt;
        logic        eq;
        logic [31:0] out;
    } alu_resp_msg_t;

    function automatic logic alu_fn_legal(input logic [3:0] fn);
        logic legal;
        case (fn)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU,
            ALU_SRA, ALU_SRL, ALU_SLL, ALU_CP0, ALU_CP1: legal = 1'b1;
            default:                                      legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lab2_proc_ProcDpathAlu.sv
`default_nettype none
// ============================================================================
// Module   : lab2_proc_ProcDpathAlu
// Brief    : Processor datapath ALU with equality/less-than comparator flags
// Revision : 1.0
// ============================================================================
module lab2_proc_ProcDpathAlu
    import lab2_proc_alu_pkg::*;
(
    input  logic [31:0] i_in0,
    input  logic [31:0] i_in1,
    input  logic [3:0]  i_fn,
    output logic [31:0] o_out,
    output logic        o_ops_eq,
    output logic        o_ops_lt,
    output logic        o_ops_ltu
);

    logic [4:0] w_shamt;

    assign w_shamt   = i_in1[4:0];
    assign o_ops_eq  = (i_in0 == i_in1);
    assign o_ops_lt  = ($signed(i_in0) < $signed(i_in1));
    assign o_ops_ltu = (i_in0 < i_in1);

    always_comb begin
        o_out = 32'h0;
        case (i_fn)
            ALU_ADD:  o_out = i_in0 + i_in1;
            ALU_SUB:  o_out = i_in0 - i_in1;
            ALU_AND:  o_out = i_in0 & i_in1;
            ALU_OR:   o_out = i_in0 | i_in1;
            ALU_XOR:  o_out = i_in0 ^ i_in1;
            ALU_SLT:  o_out = {31'h0, o_ops_lt};
            ALU_SLTU: o_out = {31'h0, o_ops_ltu};
            ALU_SRA:  o_out = $unsigned($signed(i_in0) >>> w_shamt);
            ALU_SRL:  o_out = i_in0 >> w_shamt;
            ALU_SLL:  o_out = i_in0 << w_shamt;
            ALU_CP0:  o_out = i_in0;
            ALU_CP1:  o_out = i_in1;
            default:  o_out = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lab2_proc_alu_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : lab2_proc_alu_rr_arb2
// Brief    : Two-way round-robin arbiter; the granted port loses priority
// Revision : 1.0
// ============================================================================
module lab2_proc_alu_rr_arb2 #(
    parameter int RESET_PRIO = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_grant0,
    output logic o_grant1
);

    logic r_prio;

    assign o_grant0 = i_req0 && (!i_req1 || (r_prio == 1'b0));
    assign o_grant1 = i_req1 && (!i_req0 || (r_prio == 1'b1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prio <= 1'(RESET_PRIO);
        end else if (o_grant0) begin
            r_prio <= 1'b1;
        end else if (o_grant1) begin
            r_prio <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lab2_proc_alu_arb.sv
`default_nettype none
// ============================================================================
// Module   : lab2_proc_alu_arb
// Brief    : One ALU shared by two val/rdy requesters, one-entry response
//            buffer per port (latency 1, full throughput)
// Revision : 1.0
// ============================================================================
module lab2_proc_alu_arb
    import lab2_proc_alu_pkg::*;
#(
    parameter int NPORTS     = 2,
    parameter int RESET_PRIO = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_val,
    output logic        req0_rdy,
    input  logic [67:0] req0_msg,
    output logic        resp0_val,
    input  logic        resp0_rdy,
    output logic [35:0] resp0_msg,
    input  logic        req1_val,
    output logic        req1_rdy,
    input  logic [67:0] req1_msg,
    output logic        resp1_val,
    input  logic        resp1_rdy,
    output logic [35:0] resp1_msg,
    output logic        busy
);

    if (NPORTS != 2) begin : g_nports_check
        $error("lab2_proc_alu_arb supports exactly two ports");
    end

    logic          r_full0;
    logic          r_full1;
    alu_resp_msg_t r_rbuf0;
    alu_resp_msg_t r_rbuf1;

    logic          w_elig0;
    logic          w_elig1;
    logic          w_grant0;
    logic          w_grant1;
    alu_req_msg_t  w_req;
    alu_resp_msg_t w_resp;
    logic [31:0]   w_alu_out;
    logic          w_eq;
    logic          w_lt;
    logic          w_ltu;
    logic          w_legal;

    // A slot being drained this cycle can accept a new result at the same edge.
    assign w_elig0 = req0_val && (!r_full0 || resp0_rdy);
    assign w_elig1 = req1_val && (!r_full1 || resp1_rdy);

    lab2_proc_alu_rr_arb2 #(
        .RESET_PRIO (RESET_PRIO)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .i_req0   (w_elig0),
        .i_req1   (w_elig1),
        .o_grant0 (w_grant0),
        .o_grant1 (w_grant1)
    );

    assign w_req = w_grant1 ? alu_req_msg_t'(req1_msg) : alu_req_msg_t'(req0_msg);

    lab2_proc_ProcDpathAlu u_alu (
        .i_in0     (w_req.in0),
        .i_in1     (w_req.in1),
        .i_fn      (w_req.fn),
        .o_out     (w_alu_out),
        .o_ops_eq  (w_eq),
        .o_ops_lt  (w_lt),
        .o_ops_ltu (w_ltu)
    );

    assign w_legal    = alu_fn_legal(w_req.fn);
    assign w_resp.err = !w_legal;
    assign w_resp.ltu = w_ltu;
    assign w_resp.lt  = w_lt;
    assign w_resp.eq  = w_eq;
    assign w_resp.out = w_legal ? w_alu_out : 32'h0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full0 <= 1'b0;
            r_full1 <= 1'b0;
            r_rbuf0 <= '0;
            r_rbuf1 <= '0;
        end else begin
            if (w_grant0) begin
                r_full0 <= 1'b1;
                r_rbuf0 <= w_resp;
            end else if (r_full0 && resp0_rdy) begin
                r_full0 <= 1'b0;
            end
            if (w_grant1) begin
                r_full1 <= 1'b1;
                r_rbuf1 <= w_resp;
            end else if (r_full1 && resp1_rdy) begin
                r_full1 <= 1'b0;
            end
        end
    end

    assign req0_rdy  = w_grant0;
    assign req1_rdy  = w_grant1;
    assign resp0_val = r_full0;
    assign resp1_val = r_full1;
    assign resp0_msg = r_rbuf0;
    assign resp1_msg = r_rbuf1;
    assign busy      = r_full0 | r_full1;

endmodule
`default_nettype wire
